// File: rtl/alu_ctrl_pkg.sv
// Shared state encoding, ALU opcode constants and opcode helpers for the
// register/ALU transfer sequencer.
package alu_ctrl_pkg;

  localparam int unsigned OP_LEN = 5;

  typedef enum logic [2:0] {
    IDLE,
    T_B,
    T_C,
    T_W,
    T_H
  } state_e;

  localparam logic [OP_LEN-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_LEN-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_LEN-1:0] OP_AND = 5'b00101;
  localparam logic [OP_LEN-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_LEN-1:0] OP_MUL = 5'b01110;
  localparam logic [OP_LEN-1:0] OP_DIV = 5'b01111;

  // MUL/DIV produce a 64-bit result needing a second writeback cycle for HI.
  function automatic logic is_multicycle(input logic [OP_LEN-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Index-to-one-hot register strobe decoder; all-zero when disabled or when
// the index does not name an existing register.
module reg_sel_decoder #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                i_en,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_en && (int'(i_idx) == i)) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_xfer_sequencer.sv
// Multi-cycle bus sequencer: steps one register-to-register ALU request through
// the B-operand, C-operand and writeback cycles with Moore-decoded strobes.
module alu_xfer_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_W     = 5,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [IDX_W-1:0]    req_ra,
  input  logic [IDX_W-1:0]    req_rb,
  input  logic [IDX_W-1:0]    req_rc,
  input  logic                req_imm,
  input  logic                req_ba,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                BAout,
  output logic                Cout,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [OP_W-1:0]     alu_op,
  output logic                done,
  output logic                busy
);

  state_e             r_state;
  state_e             w_state_next;
  logic [OP_W-1:0]    r_op;
  logic [IDX_W-1:0]   r_ra;
  logic [IDX_W-1:0]   r_rb;
  logic [IDX_W-1:0]   r_rc;
  logic               r_imm;
  logic               r_ba;

  logic               w_rout_en;
  logic [IDX_W-1:0]   w_rout_idx;
  logic               w_rin_en;
  logic               w_multi;
  logic               w_rb_zero_ba;

  assign w_multi      = is_multicycle(OP_LEN'(r_op));
  assign w_rb_zero_ba = r_ba && (r_rb == '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_imm   <= 1'b0;
      r_ba    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && req_valid) begin
        r_op  <= req_op;
        r_ra  <= req_ra;
        r_rb  <= req_rb;
        r_rc  <= req_rc;
        r_imm <= req_imm;
        r_ba  <= req_ba;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rout_en    = 1'b0;
    w_rout_idx   = r_rb;
    w_rin_en     = 1'b0;
    req_ready    = 1'b0;
    BAout        = 1'b0;
    Cout         = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    Zlowout      = 1'b0;
    Zhighout     = 1'b0;
    LOin         = 1'b0;
    HIin         = 1'b0;
    alu_op       = '0;
    done         = 1'b0;
    busy         = (r_state != IDLE);

    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = T_B;
        end
      end
      T_B: begin
        // Base-address mode reads R0 as zero instead of driving it.
        BAout        = w_rb_zero_ba;
        w_rout_en    = !w_rb_zero_ba;
        w_rout_idx   = r_rb;
        Yin          = 1'b1;
        w_state_next = T_C;
      end
      T_C: begin
        Cout         = r_imm;
        w_rout_en    = !r_imm;
        w_rout_idx   = r_rc;
        alu_op       = r_op;
        Zin          = 1'b1;
        w_state_next = T_W;
      end
      T_W: begin
        Zlowout = 1'b1;
        if (w_multi) begin
          LOin         = 1'b1;
          w_state_next = T_H;
        end else begin
          w_rin_en     = 1'b1;
          done         = 1'b1;
          w_state_next = IDLE;
        end
      end
      T_H: begin
        Zhighout     = 1'b1;
        HIin         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  reg_sel_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rout_dec (
    .i_en     (w_rout_en),
    .i_idx    (w_rout_idx),
    .o_onehot (Rout)
  );

  reg_sel_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rin_dec (
    .i_en     (w_rin_en),
    .i_idx    (r_ra),
    .o_onehot (Rin)
  );

endmodule

// File: tb/tb_alu_xfer_sequencer.sv
// Randomized self-checking bench for alu_xfer_sequencer against a per-cycle
// expected-strobe model built from the request fields.
module tb_alu_xfer_sequencer;

  localparam logic [4:0] M_ADD = 5'b00011;
  localparam logic [4:0] M_SUB = 5'b00100;
  localparam logic [4:0] M_AND = 5'b00101;
  localparam logic [4:0] M_OR  = 5'b00110;
  localparam logic [4:0] M_MUL = 5'b01110;
  localparam logic [4:0] M_DIV = 5'b01111;
  localparam logic [15:0] ONE16 = 16'd1;

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic        baout;
    logic        cout;
    logic        yin;
    logic        zin;
    logic        zlo;
    logic        zhi;
    logic        loin;
    logic        hiin;
    logic [4:0]  aluop;
    logic        done;
    logic        busy;
    logic        ready;
  } obs_t;

  logic        clk;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [3:0]  req_ra;
  logic [3:0]  req_rb;
  logic [3:0]  req_rc;
  logic        req_imm;
  logic        req_ba;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        BAout;
  logic        Cout;
  logic        Yin;
  logic        Zin;
  logic        Zlowout;
  logic        Zhighout;
  logic        LOin;
  logic        HIin;
  logic [4:0]  alu_op;
  logic        done;
  logic        busy;

  obs_t        act;
  obs_t        idle_obs;
  obs_t        exp_q[$];
  int          errors;
  int          checks;
  logic [4:0]  op_tab[6];

  alu_xfer_sequencer #(
    .NUM_REGS (16),
    .OP_W     (5),
    .IDX_W    (4)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_ra    (req_ra),
    .req_rb    (req_rb),
    .req_rc    (req_rc),
    .req_imm   (req_imm),
    .req_ba    (req_ba),
    .Rout      (Rout),
    .Rin       (Rin),
    .BAout     (BAout),
    .Cout      (Cout),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zlowout   (Zlowout),
    .Zhighout  (Zhighout),
    .LOin      (LOin),
    .HIin      (HIin),
    .alu_op    (alu_op),
    .done      (done),
    .busy      (busy)
  );

  assign act = {Rout, Rin, BAout, Cout, Yin, Zin, Zlowout, Zhighout, LOin, HIin,
                alu_op, done, busy, req_ready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs, one entry per cycle, for a request accepted at an edge.
  function automatic void push_expected(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc,
                                        input logic imm, input logic ba);
    obs_t o;
    logic mc;
    mc = (op == M_MUL) || (op == M_DIV);
    o = '0; o.busy = 1'b1; o.yin = 1'b1;
    if (ba && rb == 4'd0) o.baout = 1'b1;
    else o.rout = ONE16 << rb;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.zin = 1'b1; o.aluop = op;
    if (imm) o.cout = 1'b1;
    else o.rout = ONE16 << rc;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.zlo = 1'b1;
    if (mc) o.loin = 1'b1;
    else begin
      o.rin  = ONE16 << ra;
      o.done = 1'b1;
    end
    exp_q.push_back(o);
    if (mc) begin
      o = '0; o.busy = 1'b1; o.zhi = 1'b1; o.hiin = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
    end
  endfunction

  function automatic logic [4:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return op_tab[$urandom_range(0, 5)];
  endfunction

  task automatic scramble_fields();
    req_op  = 5'($urandom);
    req_ra  = 4'($urandom);
    req_rb  = 4'($urandom);
    req_rc  = 4'($urandom);
    req_imm = 1'($urandom);
    req_ba  = 1'($urandom);
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic run_req(input string name, input logic [4:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc,
                         input logic imm, input logic ba);
    obs_t e;
    int   n;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready-before: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_rc = rc;
    req_imm = imm; req_ba = ba;
    @(negedge clk);
    req_valid = 1'b0;
    scramble_fields();
    push_expected(op, ra, rb, rc, imm, ba);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle%0d: got %h want %h", name, i + 1, act, e);
      end
      @(negedge clk);
    end
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL %s back-to-idle: got %h want %h", name, act, idle_obs);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    req_valid = 1'b1;
    scramble_fields();
    @(negedge clk);
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL reset_during_clear: got %h want %h", act, idle_obs);
    end
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL reset_after_clear: got %h want %h", act, idle_obs);
    end
  endtask

  task automatic test_normal();
    run_req("add_directed", M_ADD, 4'd3, 4'd5, 4'd7, 1'b0, 1'b0);
    run_req("sub_imm", M_SUB, 4'd15, 4'd9, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      run_req("rand_op", rand_op(), 4'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_r0();
    run_req("r0_ba1", M_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 1'b1);
    run_req("r0_ba0", M_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0);
    run_req("ra0_write", M_OR, 4'd0, 4'd0, 4'd4, 1'b0, 1'b1);
  endtask

  task automatic test_multicycle();
    run_req("mul", M_MUL, 4'd1, 4'd4, 4'd6, 1'b0, 1'b0);
    run_req("div_ba", M_DIV, 4'd8, 4'd0, 4'd2, 1'b1, 1'b1);
  endtask

  task automatic test_mid_clear();
    obs_t e;
    req_valid = 1'b1;
    req_op = M_AND; req_ra = 4'd6; req_rb = 4'd10; req_rc = 4'd11;
    req_imm = 1'b0; req_ba = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    push_expected(M_AND, 4'd6, 4'd10, 4'd11, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL midclr_pre cycle%0d: got %h want %h", i + 1, act, e);
      end
      if (i == 1) clear = 1'b1;
      @(negedge clk);
    end
    exp_q.delete();
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL midclr_abort: got %h want %h", act, idle_obs);
    end
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL midclr_stay_idle: got %h want %h", act, idle_obs);
    end
    run_req("after_clear", M_MUL, 4'd12, 4'd13, 4'd14, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic accept;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic imm, ba;
    exp_q.delete();
    for (int c = 0; c < 120; c++) begin
      if (exp_q.size() == 0) begin
        e = idle_obs;
        accept = 1'b1;
      end else begin
        e = exp_q.pop_front();
        accept = 1'b0;
      end
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL hold cyc%0d: got %h want %h", c, act, e);
      end
      checks++;
      if (!$onehot0(Rout) || !$onehot0(Rin) || ((|Rout) && (BAout || Cout))) begin
        errors++;
        $display("FAIL hold_invariant cyc%0d: got Rout=%h Rin=%h BA=%b C=%b want one-hot",
                 c, Rout, Rin, BAout, Cout);
      end
      op = rand_op(); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      imm = 1'($urandom); ba = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) rb = 4'd0;
      req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_rc = rc;
      req_imm = imm; req_ba = ba;
      if (accept) push_expected(op, ra, rb, rc, imm, ba);
      @(negedge clk);
    end
    req_valid = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL hold_drain: got %h want %h", act, e);
      end
      @(negedge clk);
    end
    checks++;
    if (act !== idle_obs) begin
      errors++;
      $display("FAIL hold_final_idle: got %h want %h", act, idle_obs);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    op_tab = '{M_ADD, M_SUB, M_AND, M_OR, M_MUL, M_DIV};
    idle_obs = '0;
    idle_obs.ready = 1'b1;
    clear = 1'b1;
    req_valid = 1'b0;
    req_op = '0; req_ra = '0; req_rb = '0; req_rc = '0; req_imm = 1'b0; req_ba = 1'b0;
    test_reset();
    test_normal();
    test_r0();
    test_multicycle();
    test_mid_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
